phy_tx: RTL
===========

Name: phy_tx

Overview:
Serializing transmit PHY; the counterpart of phy_rx.
- Accepts 32-bit parallel words via a valid/ready handshake and drives them on two serial lanes, MSB-first, on clk32.
- After reset, and after every re-enable, sends a COM (0xBC) sync preamble so phy_rx can align.
- Fills slots with no data with IDLE (0x7C).

Parameters:
SYNC_SLOTS, 2, number of COM slots sent after reset/enable (each slot = 2 COM bytes per lane; default gives 4 COM bytes per lane)
COM_SYM, 8'hBC, sync/comma symbol
IDLE_SYM, 8'h7C, idle fill symbol
SKP_SYM, 8'h1C, skip symbol (used only with PHY_TX_SKP_EN)
SKP_INTERVAL, 16, post-sync slots between SKP slots (used only with PHY_TX_SKP_EN)

Ports:
clk32  input  1  serial bit clock, all logic on rising edge
reset_L  input  1  asynchronous, active-low reset
enable  input  1  transmit enable, sampled every edge
data_in  input  32  word to transmit
valid_in  input  1  data_in valid
ready_out  output  1  block accepts a word on this edge
serial_o0  output  1  lane 0 serial data
serial_o1  output  1  lane 1 serial data
active  output  1  sync preamble complete, link carrying IDLE/data

Behaviour:
- Reset values: serial_o0=0, serial_o1=0, ready_out=0, active=0.
- Internal reset state: FSM=OFF, bit_cnt=0, sync_cnt=0.
- Timing unit is a slot of 16 clk32 cycles; bit_cnt runs 0..15 and wraps.
- Each lane has a 16-bit shift register; the lane output is its MSB, registered.
- Lane mapping for data: lane0 = data_in[31:16]; lane1 = data_in[15:0]. Each lane sends its upper byte first, MSB-first.
- FSM states:
  - OFF: outputs 0, counters held at 0. On the first edge with enable=1, go to SYNC and load COM_SYM,COM_SYM into both lanes. The MSB (1) appears after that edge.
  - SYNC: at bit_cnt==15, increment sync_cnt. If sync_cnt==SYNC_SLOTS-1, go to RUN; otherwise reload COM.
  - RUN: at every bit_cnt==15 the next slot is loaded. On a transfer, load data_in; otherwise load IDLE_SYM,IDLE_SYM.
- ready_out: registered. High exactly in cycles where bit_cnt==15 and either state is RUN, or state is SYNC with sync_cnt==SYNC_SLOTS-1. This lets the first word follow the preamble with no gap.
- Transfer occurs on an edge where enable, valid_in and ready_out are all 1. data_in is sampled only on that edge.
- Latency: the word's bit 31 (lane0) and bit 15 (lane1) appear in the cycle right after the transfer edge.
- Back-to-back words: possible every 16 cycles, with no IDLE between them.
- active: goes to 1 at the first RUN slot load (same edge the first post-sync slot starts). Cleared in OFF.
- enable=0 on any edge, including mid-slot: go to OFF on that edge. The partial slot is discarded, outputs go to 0, and no transfer occurs. Re-enable always restarts the full preamble.
- reset_L low mid-slot: all state and outputs go to reset values immediately, with no clock needed.

Optional Feature:
PHY_TX_SKP_EN
- Defined: a RUN slot counter counts loaded slots. After SKP_INTERVAL consecutive RUN slots, the next slot is SKP_SYM,SKP_SYM on both lanes and the counter restarts.
- ready_out is held 0 at the boundary that loads a SKP slot, so no word is lost.
- The counter clears in OFF and on reset.
- Not defined: no SKP slots; ready_out is as described in Behaviour.

Test Plan:
1. Reset released, enable=1, valid_in=0 -> per lane 0xBC x4 bytes (cycles 1-32), then 0x7C repeating. ready_out pulses at cycles 32, 48, ... (counting the first post-reset edge as cycle 1). active=1 from cycle 33.
2. data_in=0xFFEEFFEE held valid during sync -> accepted on the final SYNC cycle-15 edge. Lane0 and lane1 each show 0xFF then 0xEE (16 cycles). ready_out goes low after the transfer until the next boundary.
3. Words 0xA5A5_0F0F then 0x1234_5678, valid continuously -> lane0 A5,A5,12,34 and lane1 0F,0F,56,78 back-to-back, no IDLE between them. Then 0x7C.
4. enable dropped at bit_cnt=7 of a data slot -> outputs 0 next edge, active=0, no ready_out. On re-enable the full 4x0xBC preamble precedes any data.
5. reset_L pulsed low mid-SYNC slot -> outputs 0 asynchronously. After release, the preamble restarts from the first COM byte.
6. PHY_TX_SKP_EN defined, SKP_INTERVAL=2, valid_in held 1 -> slot sequence data, data, SKP(0x1C x2 per lane), data. ready_out is absent at the boundary before the SKP slot, and the data word is held, not dropped.

Source files
------------

// File: rtl/phy_tx.sv
// Two-lane serializing transmit PHY: COM preamble after reset/enable, then 32-bit words or IDLE fill.
// Optional SKP insertion is enabled by defining PHY_TX_SKP_EN.
module phy_tx #(
   parameter int unsigned SYNC_SLOTS   = 2,
   parameter logic [7:0]  COM_SYM      = 8'hBC,
   parameter logic [7:0]  IDLE_SYM     = 8'h7C,
   parameter logic [7:0]  SKP_SYM      = 8'h1C,
   parameter int unsigned SKP_INTERVAL = 16
) (
   input  logic        clk32,
   input  logic        reset_L,
   input  logic        enable,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic        serial_o0,
   output logic        serial_o1,
   output logic        active
);

   localparam int unsigned    SCW       = (SYNC_SLOTS > 1) ? $clog2(SYNC_SLOTS) : 1;
   localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_SLOTS - 1);

   typedef enum logic [1:0] {ST_OFF, ST_SYNC, ST_RUN} state_t;

   state_t         state_q, state_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [SCW-1:0] sync_cnt_q, sync_cnt_d;
   logic [15:0]    sh0_q, sh0_d;
   logic [15:0]    sh1_q, sh1_d;
   logic           ready_q, ready_d;
   logic           active_q, active_d;
   logic           load_run;
   logic           xfer;

`ifdef PHY_TX_SKP_EN
   localparam int unsigned    RCW    = $clog2(SKP_INTERVAL + 1);
   localparam logic [RCW-1:0] SKP_AT = RCW'(SKP_INTERVAL);
   logic [RCW-1:0] run_cnt_q, run_cnt_d;
`endif

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q + 4'd1;
      sync_cnt_d = sync_cnt_q;
      sh0_d      = {sh0_q[14:0], 1'b0};
      sh1_d      = {sh1_q[14:0], 1'b0};
      active_d   = active_q;
      load_run   = 1'b0;
      xfer       = valid_in & ready_q;
`ifdef PHY_TX_SKP_EN
      run_cnt_d  = run_cnt_q;
`endif
      if (!enable) begin
         state_d    = ST_OFF;
         bit_cnt_d  = '0;
         sync_cnt_d = '0;
         sh0_d      = '0;
         sh1_d      = '0;
         active_d   = 1'b0;
`ifdef PHY_TX_SKP_EN
         run_cnt_d  = '0;
`endif
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d    = ST_SYNC;
               bit_cnt_d  = '0;
               sync_cnt_d = '0;
               sh0_d      = {COM_SYM, COM_SYM};
               sh1_d      = {COM_SYM, COM_SYM};
            end
            ST_SYNC: begin
               if (bit_cnt_q == 4'd15) begin
                  if (sync_cnt_q == SYNC_LAST) begin
                     state_d  = ST_RUN;
                     active_d = 1'b1;
                     load_run = 1'b1;
                  end else begin
                     sync_cnt_d = sync_cnt_q + 1'b1;
                     sh0_d      = {COM_SYM, COM_SYM};
                     sh1_d      = {COM_SYM, COM_SYM};
                  end
               end
            end
            ST_RUN: begin
               if (bit_cnt_q == 4'd15) load_run = 1'b1;
            end
            default: begin
               state_d    = ST_OFF;
               bit_cnt_d  = '0;
               sync_cnt_d = '0;
               sh0_d      = '0;
               sh1_d      = '0;
               active_d   = 1'b0;
            end
         endcase
      end

      // ready_q is only ever high on a slot boundary, so xfer implies load_run
      if (load_run) begin
         if (xfer) begin
            sh0_d = data_in[31:16];
            sh1_d = data_in[15:0];
         end else begin
            sh0_d = {IDLE_SYM, IDLE_SYM};
            sh1_d = {IDLE_SYM, IDLE_SYM};
         end
`ifdef PHY_TX_SKP_EN
         run_cnt_d = run_cnt_q + 1'b1;
         if (run_cnt_q == SKP_AT) begin
            sh0_d     = {SKP_SYM, SKP_SYM};
            sh1_d     = {SKP_SYM, SKP_SYM};
            run_cnt_d = '0;
         end
`endif
      end

      ready_d = (bit_cnt_d == 4'd15) &&
                ((state_d == ST_RUN) || ((state_d == ST_SYNC) && (sync_cnt_d == SYNC_LAST)));
`ifdef PHY_TX_SKP_EN
      if (run_cnt_d == SKP_AT) ready_d = 1'b0;
`endif
   end

   always_ff @(posedge clk32 or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= ST_OFF;
         bit_cnt_q  <= '0;
         sync_cnt_q <= '0;
         sh0_q      <= '0;
         sh1_q      <= '0;
         ready_q    <= 1'b0;
         active_q   <= 1'b0;
`ifdef PHY_TX_SKP_EN
         run_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sync_cnt_q <= sync_cnt_d;
         sh0_q      <= sh0_d;
         sh1_q      <= sh1_d;
         ready_q    <= ready_d;
         active_q   <= active_d;
`ifdef PHY_TX_SKP_EN
         run_cnt_q  <= run_cnt_d;
`endif
      end
   end

   assign serial_o0 = sh0_q[15];
   assign serial_o1 = sh1_q[15];
   assign ready_out = ready_q;
   assign active    = active_q;

endmodule
